// File: rtl/cr_bmu_tcipif_ibus_req.sv
// BMU-side initiator for the TCIPIF instruction bus: one outstanding request, IDLE/REQ/WAIT handshake.
// Optional hang timeout enabled by defining CR_TCIPIF_IBUS_TIMEOUT_EN.
module cr_bmu_tcipif_ibus_req #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        sel_cpuclk,
    input  logic        cpurst_b,
    input  logic        ifu_bmu_ibus_req,
    input  logic [31:0] ifu_bmu_ibus_addr,
    input  logic        ifu_bmu_ibus_write,
    input  logic        ifu_bmu_ibus_deny,
    output logic        bmu_ifu_ibus_grnt,
    output logic        bmu_ifu_ibus_trans_cmplt,
    output logic        bmu_ifu_ibus_acc_err,
    output logic        bmu_ifu_ibus_data_vld,
    output logic [31:0] bmu_ifu_ibus_rdata,
    output logic        bmu_tcipif_ibus_req,
    output logic [31:0] bmu_tcipif_ibus_addr,
    output logic        bmu_tcipif_ibus_write,
    output logic        bmu_tcipif_ibus_acc_deny,
    input  logic        tcipif_bmu_ibus_grnt,
    input  logic        tcipif_bmu_ibus_trans_cmplt,
    input  logic        tcipif_bmu_ibus_acc_err,
    input  logic        tcipif_bmu_ibus_data_vld,
    input  logic [31:0] tcipif_bmu_ibus_data,
    output logic        bmu_ibus_busy
);

    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, WAIT = 2'b10} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic        write_q, deny_q;
    logic        ifu_grnt;
    logic        timeout;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    assign ifu_grnt = (state_q == IDLE) && ifu_bmu_ibus_req;

`ifdef CR_TCIPIF_IBUS_TIMEOUT_EN
    logic [7:0] cnt_q;

    // A responder completion in the expiry cycle wins over the forced abort.
    assign timeout = ((state_q == REQ) || (state_q == WAIT))
                  && (cnt_q == 8'(TIMEOUT_CYCLES - 1))
                  && !((state_q == WAIT) && tcipif_bmu_ibus_trans_cmplt);

    always_ff @(posedge sel_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b)
            cnt_q <= 8'd0;
        else if (ifu_grnt)
            cnt_q <= 8'd0;
        else if ((state_q == REQ) || (state_q == WAIT))
            cnt_q <= cnt_q + 8'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge sel_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ifu_bmu_ibus_req) state_d = REQ;
            REQ:     if (timeout) state_d = IDLE;
                     else if (tcipif_bmu_ibus_grnt) state_d = WAIT;
            WAIT:    if (tcipif_bmu_ibus_trans_cmplt || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bmu_ifu_ibus_grnt        = 1'b0;
        bmu_ifu_ibus_trans_cmplt = 1'b0;
        bmu_ifu_ibus_acc_err     = 1'b0;
        bmu_ifu_ibus_data_vld    = 1'b0;
        bmu_ifu_ibus_rdata       = 32'd0;
        bmu_tcipif_ibus_req      = 1'b0;
        case (state_q)
            IDLE: bmu_ifu_ibus_grnt = ifu_bmu_ibus_req;
            REQ: begin
                bmu_tcipif_ibus_req      = !timeout;
                bmu_ifu_ibus_trans_cmplt = timeout;
                bmu_ifu_ibus_acc_err     = timeout;
            end
            WAIT: begin
                if (tcipif_bmu_ibus_trans_cmplt) begin
                    bmu_ifu_ibus_trans_cmplt = 1'b1;
                    bmu_ifu_ibus_acc_err     = tcipif_bmu_ibus_acc_err;
                    bmu_ifu_ibus_data_vld    = tcipif_bmu_ibus_data_vld && !tcipif_bmu_ibus_acc_err;
                    if (tcipif_bmu_ibus_data_vld && !tcipif_bmu_ibus_acc_err)
                        bmu_ifu_ibus_rdata = tcipif_bmu_ibus_data;
                end else if (timeout) begin
                    bmu_ifu_ibus_trans_cmplt = 1'b1;
                    bmu_ifu_ibus_acc_err     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Bus-side attributes persist after completion; only an IFU grant reloads them.
    always_ff @(posedge sel_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            addr_q  <= 32'd0;
            write_q <= 1'b0;
            deny_q  <= 1'b0;
        end else if (ifu_grnt) begin
            addr_q  <= ifu_bmu_ibus_addr;
            write_q <= ifu_bmu_ibus_write;
            deny_q  <= ifu_bmu_ibus_deny;
        end
    end

    assign bmu_tcipif_ibus_addr     = addr_q;
    assign bmu_tcipif_ibus_write    = write_q;
    assign bmu_tcipif_ibus_acc_deny = deny_q;
    assign bmu_ibus_busy            = (state_q != IDLE);

endmodule
